// File: rtl/constants_pkg.sv
// Shared widths and response payload type for the fetch memory responder.
package constants_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 32;

    // One fetch response: read data plus out-of-range flag.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } fetch_rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// Response FIFO: DEPTH entries (power of two), pointers wrap naturally.
module rsp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data_c,
    output logic             o_empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push    = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop     = i_pop && (r_count != '0);
    assign o_empty_c = (r_count == '0);
    assign o_data_c  = r_mem[r_rd_ptr];

    // Entry storage; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_mem_responder.sv
// Host-preloaded word memory answering read requests with a fixed two-cycle
// latency through a response FIFO; outstanding reads are capped at the FIFO
// depth so the FIFO can never overflow.
module fetch_mem_responder #(
    parameter int unsigned ADDR_WIDTH = constants_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = constants_pkg::DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_req_vld,
    output logic                  m_req_rdy,
    input  logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_rsp_vld,
    input  logic                  m_rsp_rdy,
    output logic [DATA_WIDTH-1:0] m_rsp_data,
    output logic                  m_rsp_err,
    input  logic                  ld_vld,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  busy
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned RSP_W = DATA_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic                  r_s1_vld;
    logic                  r_s1_err;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic [CNT_W-1:0]      r_outstanding;

    logic                  w_req_in_range;
    logic                  w_ld_in_range;
    logic [IDX_W-1:0]      w_req_idx;
    logic [IDX_W-1:0]      w_ld_idx;
    logic                  w_accept;
    logic                  w_pop;
    logic [RSP_W-1:0]      w_fifo_data;
    logic                  w_fifo_empty;

    assign w_req_in_range = (64'(m_req_addr) < 64'(MEM_DEPTH));
    assign w_ld_in_range  = (64'(ld_addr) < 64'(MEM_DEPTH));
    assign w_req_idx      = m_req_addr[IDX_W-1:0];
    assign w_ld_idx       = ld_addr[IDX_W-1:0];

    // Preload has priority: a load cycle refuses requests so the read port is free.
    assign m_req_rdy = !rst && (r_outstanding < CNT_W'(RSP_DEPTH)) && !ld_vld;
    assign w_accept  = m_req_vld && m_req_rdy;

    assign m_rsp_vld  = !rst && !w_fifo_empty;
    assign w_pop      = m_rsp_vld && m_rsp_rdy;
    assign m_rsp_data = m_rsp_vld ? w_fifo_data[DATA_WIDTH-1:0] : '0;
    assign m_rsp_err  = m_rsp_vld ? w_fifo_data[DATA_WIDTH] : 1'b0;
    assign busy       = !rst && (r_outstanding != '0);

    // Host preload port; out-of-range addresses are dropped. Not reset.
    always_ff @(posedge clk) begin
        if (ld_vld && w_ld_in_range) begin
            r_mem[w_ld_idx] <= ld_data;
        end
    end

    // Read stage: samples the array at the acceptance edge, skips it when out of range.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_err  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_err  <= !w_req_in_range;
                r_s1_data <= w_req_in_range ? r_mem[w_req_idx] : '0;
            end
        end
    end

    // Outstanding = read stage plus FIFO occupancy; accept and pop together cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (r_s1_vld),
        .i_data    ({r_s1_err, r_s1_data}),
        .i_pop     (w_pop),
        .o_data_c  (w_fifo_data),
        .o_empty_c (w_fifo_empty)
    );

endmodule
